// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared types and constants for the expression stream checker
package expr_pkg;

    // FSM state; the encoding is visible on the status port.
    typedef enum logic [1:0] {
        EXPECT = 2'd0,
        NUM    = 2'd1,
        CLOSED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    // Error codes, only the first one is retained.
    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_SYNTAX    = 2'd1;
    localparam logic [1:0] ERR_DEPTH     = 2'd2;
    localparam logic [1:0] ERR_UNMATCHED = 2'd3;

    typedef enum logic [2:0] {
        CC_DIGIT = 3'd0,
        CC_OP    = 3'd1,
        CC_LP    = 3'd2,
        CC_RP    = 3'd3,
        CC_OTHER = 3'd4
    } char_class_t;

    localparam logic [7:0] CH_LP    = 8'h28;  // (
    localparam logic [7:0] CH_RP    = 8'h29;  // )
    localparam logic [7:0] CH_PLUS  = 8'h2B;  // +
    localparam logic [7:0] CH_STAR  = 8'h2A;  // *
    localparam logic [7:0] CH_MINUS = 8'h2D;  // -
    localparam logic [7:0] CH_ZERO  = 8'h30;  // 0
    localparam logic [7:0] CH_NINE  = 8'h39;  // 9

endpackage

// File: rtl/expr_char_class.sv
// rtl/expr_char_class.sv - combinational ASCII character classifier
//
// Ports:
//   in  - ASCII character
//   cls - class of the character (digit, operator, '(', ')', other)
// ALLOW_SUB nonzero makes '-' an operator instead of OTHER.
module expr_char_class
    import expr_pkg::*;
#(
    parameter int ALLOW_SUB = 0
) (
    input  logic [7:0]  in,
    output char_class_t cls
);

    always_comb begin
        cls = CC_OTHER;
        if (in >= CH_ZERO && in <= CH_NINE) begin
            cls = CC_DIGIT;
        end else if (in == CH_PLUS || in == CH_STAR) begin
            cls = CC_OP;
        end else if (in == CH_MINUS && ALLOW_SUB != 0) begin
            cls = CC_OP;
        end else if (in == CH_LP) begin
            cls = CC_LP;
        end else if (in == CH_RP) begin
            cls = CC_RP;
        end
    end

endmodule

// File: rtl/expr_stream_checker.sv
// rtl/expr_stream_checker.sv - streaming syntax checker for ASCII arithmetic expressions
//
// Ports:
//   clk      - clock, rising edge
//   clr      - synchronous active-high reset, wins over in_valid
//   in       - ASCII character, consumed when in_valid is high
//   in_valid - qualifier for in
//   out      - prefix accepted so far is a complete, well-formed expression
//   err      - sticky error flag
//   err_code - first error: 0 none, 1 syntax/illegal, 2 depth overflow, 3 unmatched ')'
//   depth    - current open-parenthesis count
//   status   - FSM state (EXPECT, NUM, CLOSED, ERROR)
// All outputs are registered; a character taken at one edge shows after that edge.
module expr_stream_checker
    import expr_pkg::*;
#(
    parameter  int MAX_DEPTH   = 7,
    parameter  int MULTI_DIGIT = 1,
    parameter  int ALLOW_SUB   = 0,
    localparam int DW          = $clog2(MAX_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [7:0]    in,
    input  logic          in_valid,
    output logic          out,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [DW-1:0] depth,
    output logic [1:0]    status
);

    localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_DEPTH);

    char_class_t   cls;
    state_t        state_q;
    state_t        state_n;
    logic [DW-1:0] depth_n;
    logic [1:0]    code_n;

    expr_char_class #(
        .ALLOW_SUB(ALLOW_SUB)
    ) u_char_class (
        .in (in),
        .cls(cls)
    );

    // Next-state decode. Overflow and underflow are detected against the
    // current count, so the counter never moves on an erroring character.
    always_comb begin
        state_n = state_q;
        depth_n = depth;
        code_n  = err_code;
        if (in_valid) begin
            unique case (state_q)
                EXPECT: begin
                    if (cls == CC_DIGIT) begin
                        state_n = NUM;
                    end else if (cls == CC_LP) begin
                        if (depth < DEPTH_MAX) begin
                            depth_n = depth + DW'(1);
                        end else begin
                            state_n = ERROR;
                            code_n  = ERR_DEPTH;
                        end
                    end else begin
                        state_n = ERROR;
                        code_n  = ERR_SYNTAX;
                    end
                end
                NUM, CLOSED: begin
                    if (cls == CC_OP) begin
                        state_n = EXPECT;
                    end else if (cls == CC_RP) begin
                        if (depth != '0) begin
                            depth_n = depth - DW'(1);
                            state_n = CLOSED;
                        end else begin
                            state_n = ERROR;
                            code_n  = ERR_UNMATCHED;
                        end
                    end else if (cls == CC_DIGIT && state_q == NUM && MULTI_DIGIT != 0) begin
                        state_n = NUM;
                    end else begin
                        state_n = ERROR;
                        code_n  = ERR_SYNTAX;
                    end
                end
                ERROR: begin
                    // absorbing: depth and code stay frozen until clr
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= EXPECT;
            depth    <= '0;
            err_code <= ERR_NONE;
            out      <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_n;
            depth    <= depth_n;
            err_code <= code_n;
            out      <= (state_n == NUM || state_n == CLOSED) && depth_n == '0;
            err      <= (state_n == ERROR);
        end
    end

    assign status = state_q;

endmodule

// File: tb/tb_expr_stream_checker.sv
// tb/tb_expr_stream_checker.sv - directed self-checking bench for expr_stream_checker
module tb_expr_stream_checker;

    logic       clk;
    logic       clr;
    logic [7:0] in_ch;
    logic       in_valid;

    // instance a: defaults (depth 7, multi-digit, no '-')
    logic       a_out, a_err;
    logic [1:0] a_code, a_status;
    logic [2:0] a_depth;

    // instance b: depth 2, single digit, '-' allowed
    logic       b_out, b_err;
    logic [1:0] b_code, b_status;
    logic [1:0] b_depth;

    int passed = 0;
    int total  = 0;

    expr_stream_checker u_a (
        .clk     (clk),
        .clr     (clr),
        .in      (in_ch),
        .in_valid(in_valid),
        .out     (a_out),
        .err     (a_err),
        .err_code(a_code),
        .depth   (a_depth),
        .status  (a_status)
    );

    expr_stream_checker #(
        .MAX_DEPTH  (2),
        .MULTI_DIGIT(0),
        .ALLOW_SUB  (1)
    ) u_b (
        .clk     (clk),
        .clr     (clr),
        .in      (in_ch),
        .in_valid(in_valid),
        .out     (b_out),
        .err     (b_err),
        .err_code(b_code),
        .depth   (b_depth),
        .status  (b_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        in_ch    = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_ch    = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string seq;
        string exp_out;
        string exp_dep;
        string exp_st;

        clr      = 1'b1;
        in_valid = 1'b0;
        in_ch    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_out",   a_out,    0);
        check("rst_a_err",   a_err,    0);
        check("rst_a_code",  a_code,   0);
        check("rst_a_depth", a_depth,  0);
        check("rst_a_stat",  a_status, 0);
        check("rst_b_stat",  b_status, 0);
        @(negedge clk);
        clr = 1'b0;

        // main nested expression, checked after every character
        seq     = "1+(1+2)*(3+2)";
        exp_out = "1000001000001";
        exp_dep = "0011110011110";
        exp_st  = "1001012001012";
        for (int i = 0; i < seq.len(); i++) begin
            send(seq[i]);
            check($sformatf("seq_out%0d", i),   a_out,    exp_out[i] - "0");
            check($sformatf("seq_dep%0d", i),   a_depth,  exp_dep[i] - "0");
            check($sformatf("seq_st%0d", i),    a_status, exp_st[i] - "0");
            check($sformatf("seq_err%0d", i),   a_err,    0);
        end

        // digit after ')' is a syntax error, then everything freezes
        send("2");
        check("tail_err",  a_err,    1);
        check("tail_code", a_code,   1);
        check("tail_out",  a_out,    0);
        check("tail_stat", a_status, 3);
        send_str("(+)");
        idle(2);
        check("frz_err",   a_err,   1);
        check("frz_code",  a_code,  1);
        check("frz_depth", a_depth, 0);
        check("frz_out",   a_out,   0);
        reset_dut();
        check("clr_err",   a_err,    0);
        check("clr_code",  a_code,   0);
        check("clr_stat",  a_status, 0);
        check("clr_out",   a_out,    0);

        // depth overflow: b limits at 2, a at 7
        send("(");
        check("ov_b_d1", b_depth, 1);
        send("(");
        check("ov_b_d2", b_depth, 2);
        check("ov_b_e2", b_err,   0);
        send("(");
        check("ov_b_err",  b_err,   1);
        check("ov_b_code", b_code,  2);
        check("ov_b_dep",  b_depth, 2);
        check("ov_a_dep3", a_depth, 3);
        check("ov_a_err3", a_err,   0);
        send_str("((((");
        check("ov_a_dep7", a_depth, 7);
        check("ov_a_err7", a_err,   0);
        send("(");
        check("ov_a_err",  a_err,   1);
        check("ov_a_code", a_code,  2);
        check("ov_a_dep",  a_depth, 7);
        send(")");
        check("ov_a_hold", a_depth, 7);

        // unmatched ')'
        reset_dut();
        send_str("1)");
        check("um_code",  a_code,  3);
        check("um_depth", a_depth, 0);
        check("um_err",   a_err,   1);

        reset_dut();
        send_str("1+2");
        check("add_a_out", a_out, 1);
        check("add_b_out", b_out, 1);

        // multi-digit operand
        reset_dut();
        send_str("12");
        check("md_a_out",  a_out,  1);
        check("md_b_err",  b_err,  1);
        check("md_b_code", b_code, 1);

        // subtraction
        reset_dut();
        send_str("1-");
        check("sub_a_err",  a_err,  1);
        check("sub_a_code", a_code, 1);
        check("sub_b_out",  b_out,  0);
        check("sub_b_err",  b_err,  0);
        send("2");
        check("sub_b_out2", b_out, 1);

        // in_valid low with garbage on in
        reset_dut();
        check("inc_empty", a_out, 0);
        send("1");
        idle(3);
        check("iv_stat1", a_status, 1);
        check("iv_out1",  a_out,    1);
        send("+");
        idle(3);
        check("iv_stat0", a_status, 0);
        check("iv_out0",  a_out,    0);
        check("iv_err0",  a_err,    0);
        send("3");
        check("iv_out3",  a_out,    1);

        // clr together with a valid character that would otherwise be an error
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_ch    = ")";
        @(posedge clk);
        #1;
        check("cv_stat",  a_status, 0);
        check("cv_err",   a_err,    0);
        check("cv_depth", a_depth,  0);
        check("cv_out",   a_out,    0);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        send("5");
        check("cv_after", a_out, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
